// File: rtl/uart_loader_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_loader_ctrl_if
// Purpose  : Bundle of UART FIFO, instruction-memory and CPU-control signals
//            seen by the UART loader controller.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_loader_ctrl_if #(
  parameter int ADDR_W = 8
);
  // UART RX FIFO (first-word fall-through)
  logic              rx_empty;
  logic [7:0]        r_data;
  logic              rd;
  // UART TX FIFO
  logic              tx_full;
  logic [7:0]        w_data;
  logic              wr;
  // Instruction memory write port
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  // CPU control and observation
  logic              cpu_reset;
  logic              cpu_enable;
  logic              cpu_halt;
  logic [31:0]       debug_data;
  logic              busy;

  // Controller side
  modport master (
    input  rx_empty, r_data, tx_full, cpu_halt, debug_data,
    output rd, w_data, wr, imem_we, imem_addr, imem_wdata,
           cpu_reset, cpu_enable, busy
  );

  // Environment side (UART, memory, CPU)
  modport slave (
    output rx_empty, r_data, tx_full, cpu_halt, debug_data,
    input  rd, w_data, wr, imem_we, imem_addr, imem_wdata,
           cpu_reset, cpu_enable, busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_loader_ctrl
// Purpose  : Host command sequencer between the UART FIFOs and the CPU.
//            'L' loads program words, 'R' runs until halt/'H', 'S' steps one
//            cycle; debug word and ACK/NAK are returned to the host.
// Revision : 1.0 - initial release
// ============================================================================
module uart_loader_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 50000000
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  uart_loader_ctrl_if.master   bus
);

  localparam int              TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_HALT = 8'h48;
  localparam logic [7:0] RESP_ACK = 8'h06;
  localparam logic [7:0] RESP_NAK = 8'h15;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_GET_CNT   = 4'd1;
  localparam logic [3:0] S_GET_BYTE  = 4'd2;
  localparam logic [3:0] S_WRITE     = 4'd3;
  localparam logic [3:0] S_RUN       = 4'd4;
  localparam logic [3:0] S_STEP      = 4'd5;
  localparam logic [3:0] S_DBG_LATCH = 4'd6;
  localparam logic [3:0] S_SEND_DBG  = 4'd7;
  localparam logic [3:0] S_SEND_RESP = 4'd8;

  logic [3:0]        state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       dbg_q, dbg_d;
  logic [7:0]        resp_q, resp_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              cpu_en_q, cpu_en_d;
  // Holds off RX pops for the first cycle after reset release
  logic              armed_q;

  logic              consumes;
  logic              pop;
  logic              push;
  logic [7:0]        w_data_c;

  // Decide whether the current state wants a byte, and derive the strobes
  always_comb begin
    consumes = 1'b0;
    case (state_q)
      S_IDLE:     consumes = armed_q;
      S_GET_CNT,
      S_GET_BYTE,
      S_RUN:      consumes = 1'b1;
      default:    consumes = 1'b0;
    endcase
    pop  = consumes & ~bus.rx_empty;
    push = ((state_q == S_SEND_DBG) || (state_q == S_SEND_RESP)) & ~bus.tx_full;
  end

  // Next-state and datapath update rules
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    to_d        = '0;
    addr_d      = addr_q;
    word_d      = word_q;
    dbg_d       = dbg_q;
    resp_d      = resp_q;
    cpu_reset_d = cpu_reset_q;
    cpu_en_d    = cpu_en_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          case (bus.r_data)
            CMD_LOAD: state_d = S_GET_CNT;
            CMD_RUN, CMD_STEP: begin
              state_d     = (bus.r_data == CMD_RUN) ? S_RUN : S_STEP;
              cpu_reset_d = 1'b0;
              cpu_en_d    = 1'b1;
            end
            default: begin
              resp_d  = RESP_NAK;
              state_d = S_SEND_RESP;
            end
          endcase
        end
      end
      S_GET_CNT: begin
        if (pop) begin
          // A count byte of zero stands for a full 256-word block
          cnt_d       = (bus.r_data == 8'h00) ? 9'd256 : {1'b0, bus.r_data};
          cpu_reset_d = 1'b1;
          addr_d      = '0;
          idx_d       = 2'd0;
          state_d     = S_GET_BYTE;
        end
      end
      S_GET_BYTE: begin
        if (pop) begin
          word_d = {word_q[23:0], bus.r_data};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_WRITE;
        end else if (to_q == TO_LAST) begin
          resp_d  = RESP_NAK;
          state_d = S_SEND_RESP;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q - 9'd1;
        if (cnt_q == 9'd1) begin
          resp_d  = RESP_ACK;
          state_d = S_SEND_RESP;
        end else begin
          state_d = S_GET_BYTE;
        end
      end
      S_RUN: begin
        // Non-'H' bytes are popped and dropped while the CPU runs
        if (bus.cpu_halt || (pop && (bus.r_data == CMD_HALT))) begin
          cpu_en_d = 1'b0;
          state_d  = S_DBG_LATCH;
        end
      end
      S_STEP: begin
        cpu_en_d = 1'b0;
        state_d  = S_DBG_LATCH;
      end
      S_DBG_LATCH: begin
        // Sampled one cycle after the CPU stops so the last update is seen
        dbg_d   = bus.debug_data;
        idx_d   = 2'd0;
        state_d = S_SEND_DBG;
      end
      S_SEND_DBG: begin
        if (push) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            resp_d  = RESP_ACK;
            state_d = S_SEND_RESP;
          end
        end
      end
      S_SEND_RESP: begin
        if (push) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Byte presented to the TX FIFO: debug word MSB first, then the response
  always_comb begin
    w_data_c = 8'h00;
    if (state_q == S_SEND_DBG) begin
      case (idx_q)
        2'd0:    w_data_c = dbg_q[31:24];
        2'd1:    w_data_c = dbg_q[23:16];
        2'd2:    w_data_c = dbg_q[15:8];
        default: w_data_c = dbg_q[7:0];
      endcase
    end else if (state_q == S_SEND_RESP) begin
      w_data_c = resp_q;
    end
  end

  // State registers; reset aborts any transfer in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      cnt_q       <= 9'd0;
      to_q        <= '0;
      addr_q      <= '0;
      word_q      <= 32'h0;
      dbg_q       <= 32'h0;
      resp_q      <= 8'h00;
      cpu_reset_q <= 1'b1;
      cpu_en_q    <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      to_q        <= to_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      dbg_q       <= dbg_d;
      resp_q      <= resp_d;
      cpu_reset_q <= cpu_reset_d;
      cpu_en_q    <= cpu_en_d;
      armed_q     <= 1'b1;
    end
  end

  assign bus.rd         = pop;
  assign bus.wr         = push;
  assign bus.w_data     = w_data_c;
  assign bus.imem_we    = (state_q == S_WRITE);
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = word_q;
  assign bus.cpu_reset  = cpu_reset_q;
  assign bus.cpu_enable = cpu_en_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/uart_loader_ctrl.md
Name: uart_loader_ctrl

Overview:
- Command sequencer between the UART (FWFT RX/TX FIFOs) and the MIPS core.
- Parses host byte commands, loads program words into instruction memory, and gates the CPU (reset/enable).
- Returns a 32-bit debug word plus an ACK/NAK byte to the host.
- Sole driver of the UART rd/wr/w_data pins in the top level.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; must be >= 8.
- TIMEOUT, 50000000, idle clock cycles allowed between bytes of a load before abort; must be >= 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_empty  in  1  UART RX FIFO empty.
- r_data  in  8  UART RX head byte; valid whenever rx_empty=0 (FWFT).
- rd  out  1  RX pop strobe, one cycle per byte.
- tx_full  in  1  UART TX FIFO full.
- w_data  out  8  byte to transmit.
- wr  out  1  TX push strobe.
- imem_we  out  1  instruction-memory write enable.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  word to write.
- cpu_reset  out  1  active-high CPU hold-in-reset.
- cpu_enable  out  1  CPU clock enable.
- cpu_halt  in  1  CPU reached halt.
- debug_data  in  32  CPU debug word (PC).
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (async, while reset=0):
  - rd=0, wr=0, w_data=0x00, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_reset=1, cpu_enable=0, busy=0.
  - State=IDLE; byte index, word counter and timeout counter all 0.
  - Reset asserted mid-operation aborts immediately: no partial word is written and no response byte is sent.
- RX handshake:
  - rd=1 only in a cycle where rx_empty=0 and the current state consumes a byte.
  - r_data is captured on that same rising edge.
  - rd is never high while rx_empty=1.
- TX handshake:
  - wr=1 for exactly one cycle, only when tx_full=0, with w_data valid in that cycle.
  - While tx_full=1, hold the state and keep wr=0.
- States and transitions:
  - IDLE: pop one byte and decode it.
    - 0x4C 'L' -> GET_CNT.
    - 0x52 'R' -> RUN.
    - 0x53 'S' -> STEP.
    - Any other byte -> SEND_RESP with NAK 0x15.
  - GET_CNT: pop count byte N (0 means 256); set cpu_reset=1, imem_addr=0, byte index=0 -> GET_BYTE.
  - GET_BYTE:
    - Pop bytes MSB first into a 32-bit shift register.
    - After the 4th byte -> WRITE.
    - Timeout counter clears on each pop. When it reaches TIMEOUT with no pop -> SEND_RESP with NAK; words already written stay in memory.
  - WRITE:
    - imem_we=1 for one cycle with the current imem_addr and the assembled word.
    - Next cycle: imem_addr increments and the word counter decrements.
    - Counter at 0 -> SEND_RESP with ACK 0x06; otherwise -> GET_BYTE.
    - imem_addr wraps modulo 2^ADDR_W.
  - RUN:
    - cpu_reset=0, cpu_enable=1.
    - Each cycle, cpu_halt=1 or a popped byte 0x48 'H' -> cpu_enable=0 next cycle -> SEND_DBG.
    - Other bytes popped during RUN are discarded.
    - If halt and 'H' occur in the same cycle, the byte is still popped; a single SEND_DBG follows.
  - STEP: cpu_reset=0, cpu_enable=1 for exactly one cycle, then cpu_enable=0 -> SEND_DBG.
  - SEND_DBG:
    - Latch debug_data on entry.
    - Transmit 4 bytes MSB first, then -> SEND_RESP with ACK.
  - SEND_RESP: transmit 1 byte (ACK or NAK) -> IDLE.
- cpu_reset remains 0 after RUN/STEP until the next 'L' or reset.
- Latency: 'S' popped at edge T -> cpu_enable high in cycle T+1; first debug byte pushed no earlier than T+3 (tx_full=0).

Test Plan:
- Load: host sends 4C 02 11 22 33 44 AA BB CC DD -> imem_we pulses at addr 0 with 0x11223344 and at addr 1 with 0xAABBCCDD; then wr sends 0x06; busy returns to 0.
- Step: debug_data=0x00000004, host sends 53 -> cpu_enable high exactly 1 cycle; TX bytes 00 00 00 04 06.
- Run until halt: host sends 52, cpu_halt raised 100 cycles later with debug_data=0x0000002C -> cpu_enable drops next cycle; TX 00 00 00 2C 06. Repeat with 'H' (0x48) instead of cpu_halt -> same sequence.
- Bad command / timeout: host sends 7A -> TX 15. With TIMEOUT=20, host sends 4C 01 11 22 then stalls -> after 20 cycles TX 15, no imem_we, state IDLE.
- Backpressure: hold tx_full=1 during SEND_DBG for 10 cycles -> wr stays 0, no byte lost; full 5-byte sequence is sent after release.
- Reset mid-load: drop reset after 2 data bytes -> all outputs at reset values asynchronously; a fresh 4C 01 … load writes to addr 0 correctly.
